mem_initiator: RTL
==================

MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles mem_valid is held without mem_ready before abort.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  upstream request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_op  input  3  size/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (loads only).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  upstream accepts response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  2  00 ok, 01 misaligned, 10 illegal op, 11 timeout.
REQ-014 SHALL have ports mem_valid out 1, mem_ready in 1, mem_addr out 32, mem_rdata in 32, mem_wdata out 32, mem_wstrb out 4: bus initiator side.

Function
REQ-015 SHALL implement states IDLE, BUS, RESP; req_ready = (state == IDLE).
REQ-016 SHALL, on accept in IDLE, register op/addr/data; illegal op (load 011/110/111, store with op not 000/001/010) -> RESP, err 10, no bus cycle.
REQ-017 SHALL flag misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP, err 01, no bus cycle; illegal op takes priority.
REQ-018 SHALL otherwise enter BUS with mem_valid=1 registered in the cycle after accept; mem_addr = req_addr unmodified.
REQ-019 SHALL drive mem_wstrb 0001/0011/1111 for byte/half/word stores and 0000 for loads; mem_wdata = req_wdata right-justified, upper unused bytes zero.
REQ-020 SHALL hold mem_valid, mem_addr, mem_wdata, mem_wstrb stable until mem_ready sampled high.
REQ-021 SHALL clear mem_valid on the same edge mem_ready is sampled high (never high the following cycle), and capture mem_rdata on that edge.
REQ-022 SHALL, for loads, extend captured bytes [7:0] / [15:0] by sign (op 000/001) or zero (100/101); word passes through.
REQ-023 SHALL count BUS cycles from 1; at count == TIMEOUT without mem_ready, clear mem_valid, go RESP with err 11.
REQ-024 SHALL give mem_ready priority over timeout when both occur in the same cycle.
REQ-025 SHALL hold resp_valid/rdata/err stable in RESP until resp_ready; on handshake return to IDLE, resp_valid low next cycle.
REQ-026 SHALL give minimum latency accept T -> mem_valid T+1 -> mem_ready T+2 (single-wait responder) -> resp_valid T+3; error-without-bus: resp_valid T+1.
REQ-027 SHALL not accept a new request before the current response handshakes (one outstanding).

Reset
REQ-028 SHALL, on reset assertion at any time including mid-BUS, immediately force state IDLE, counter 0, all outputs 0 except req_ready, which is 1 after reset releases.
REQ-029 SHALL not issue bus activity in the first cycle after reset release unless a request is accepted that cycle.

Structure
REQ-030 SHALL place op codes, err codes, state encoding, and wstrb values in shared package mem_bus_pkg.
REQ-031 SHALL factor load extension into combinational sub-module mem_load_ext (op, raw data -> extended data).

Verification
REQ-032 SHALL cover store SW addr 0x10 data 0xDEADBEEF -> wstrb 1111 one bus cycle, resp err 00; then LW 0x10 -> rdata 0xDEADBEEF at T+3.
REQ-033 SHALL cover SB 0x21 data 0x80, then LB 0x21 -> 0xFFFFFF80, LBU 0x21 -> 0x00000080.
REQ-034 SHALL cover LH addr 0x13 -> err 01 at T+1, mem_valid never high; load op 011 -> err 10.
REQ-035 SHALL cover responder never readying with TIMEOUT=4 -> mem_valid high exactly 4 cycles, then err 11; ready on cycle 4 -> err 00.
REQ-036 SHALL cover resp_ready held low 5 cycles -> response stable, req_ready low; reset mid-BUS -> mem_valid 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus initiator: op codes, error codes,
// FSM state encoding, byte strobes and small decode helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_BYTE  = 3'b000;
  localparam logic [2:0] OP_HALF  = 3'b001;
  localparam logic [2:0] OP_WORD  = 3'b010;
  localparam logic [2:0] OP_BYTEU = 3'b100;
  localparam logic [2:0] OP_HALFU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  // Unsigned variants exist only for loads.
  function automatic logic op_illegal(input logic we, input logic [2:0] op);
    if (we) return !(op == OP_BYTE || op == OP_HALF || op == OP_WORD);
    return !(op == OP_BYTE || op == OP_HALF || op == OP_WORD ||
             op == OP_BYTEU || op == OP_HALFU);
  endfunction

  // size: low two bits of the op code (00 byte, 01 half, 10 word)
  function automatic logic op_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_wstrb(input logic [1:0] size);
    case (size)
      2'b00:   return WSTRB_BYTE;
      2'b01:   return WSTRB_HALF;
      default: return WSTRB_WORD;
    endcase
  endfunction

  function automatic logic [31:0] size_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {24'b0, data[7:0]};
      2'b01:   return {16'b0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of right-justified load data according to the op code.
module mem_load_ext
  import mem_bus_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (op_i)
      OP_BYTE:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OP_HALF:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OP_BYTEU: ext_o = {24'b0, raw_i[7:0]};
      OP_HALFU: ext_o = {16'b0, raw_i[15:0]};
      default:  ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding load/store initiator: validates a request, runs one
// valid/ready bus cycle with timeout, and returns an extended response.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   load_ext;

  mem_load_ext u_load_ext (
    .op_i  (op_q),
    .raw_i (mem_rdata),
    .ext_o (load_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      wstrb_q <= WSTRB_NONE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // mem_ready is checked before the timeout so a late ready still completes.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d = req_we;
          op_d = req_op;
          rdata_d = 32'b0;
          if (op_illegal(req_we, req_op)) begin
            state_d = ST_RESP;
            err_d   = ERR_ILLEGAL;
          end else if (op_misaligned(req_op[1:0], req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_BUS;
            err_d   = ERR_OK;
            addr_d  = req_addr;
            wdata_d = req_we ? size_wdata(req_op[1:0], req_wdata) : 32'b0;
            wstrb_d = req_we ? size_wstrb(req_op[1:0]) : WSTRB_NONE;
            valid_d = 1'b1;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_BUS: begin
        if (mem_ready) begin
          state_d = ST_RESP;
          valid_d = 1'b0;
          cnt_d   = '0;
          err_d   = ERR_OK;
          rdata_d = we_q ? 32'b0 : load_ext;
        end else if (cnt_q == TMO) begin
          state_d = ST_RESP;
          valid_d = 1'b0;
          cnt_d   = '0;
          err_d   = ERR_TIMEOUT;
          rdata_d = 32'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          err_d   = ERR_OK;
          rdata_d = 32'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = valid_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule
